// File: rtl/seek_f_pipe.sv
// Two-stage valid/ready pipeline computing f = ((s + m) << SHIFT) - s - cf per tagged beat,
// with per-channel sequence numbering. Define SEEK_F_SAT_EN to clamp negative results to 0.
module seek_f_pipe #(
    parameter int unsigned  DW    = 16,
    parameter int unsigned  SHIFT = 20,
    parameter int unsigned  FW    = 36,
    parameter int unsigned  NCH   = 4,
    parameter int unsigned  SQW   = 8,
    localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CW-1:0]  in_ch,
    input  logic [DW-1:0]  c,
    input  logic [DW-1:0]  e,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [FW-1:0]  out_f,
    output logic [CW-1:0]  out_ch,
    output logic [SQW-1:0] out_seq,
    output logic           ch_err
`ifdef SEEK_F_SAT_EN
    ,
    output logic           underflow
`endif
);
    localparam int unsigned AW = DW - 2;
    localparam int unsigned BW = 3;
    // One guard bit above the wider of the shifted term and the result keeps the sign.
    localparam int unsigned XW = ((AW + SHIFT > FW) ? AW + SHIFT : FW) + 1;

    logic                    run_q;
    logic                    s1_v_q, s1_v_d;
    logic [AW-1:0]           s1_sum_q, s1_sum_d;
    logic [BW-1:0]           s1_sub_q, s1_sub_d;
    logic [CW-1:0]           s1_ch_q, s1_ch_d;
    logic                    s2_v_q, s2_v_d;
    logic [FW-1:0]           s2_f_q, s2_f_d;
    logic [CW-1:0]           s2_ch_q, s2_ch_d;
    logic [SQW-1:0]          s2_seq_q, s2_seq_d;
    logic [NCH-1:0][SQW-1:0] cnt_q, cnt_d;
    logic                    ch_err_q, ch_err_d;
    logic                    s2_hs, s2_free, s1_adv, in_acc, in_good;
    logic [XW-1:0]           wide;
    logic [SQW-1:0]          seq_sel;
    logic                    unused_bits;
`ifdef SEEK_F_SAT_EN
    logic                    uf_q, uf_d;
    logic                    s2_neg_q, s2_neg_d;
`endif

    assign unused_bits = ^{e[DW-1:DW-2], c[DW-1], c[DW-4:0], wide[XW-1:FW]};

    // Handshakes, datapath and next-state for both stages and the bookkeeping.
    always_comb begin
        s2_hs    = s2_v_q && out_ready;
        s2_free  = !s2_v_q || out_ready;
        s1_adv   = s1_v_q && s2_free;
        in_ready = run_q && !clr && (!s1_v_q || s1_adv);
        in_acc   = in_valid && in_ready;
        in_good  = in_acc && (32'(in_ch) < NCH);

        wide = (XW'(s1_sum_q) << SHIFT) - XW'(s1_sub_q);

        // Sequence number the S1 beat will carry, bypassing a same-channel delivery this edge.
        seq_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (s1_ch_q == CW'(i)) seq_sel = cnt_q[i];
        end
        if (s2_hs && s2_ch_q == s1_ch_q) seq_sel = seq_sel + SQW'(1);

        s1_v_d   = s1_v_q && !s1_adv;
        s1_sum_d = s1_sum_q;
        s1_sub_d = s1_sub_q;
        s1_ch_d  = s1_ch_q;
        s2_v_d   = s2_v_q && !s2_hs;
        s2_f_d   = s2_f_q;
        s2_ch_d  = s2_ch_q;
        s2_seq_d = s2_seq_q;
        cnt_d    = cnt_q;
        ch_err_d = ch_err_q || (in_acc && !in_good);
`ifdef SEEK_F_SAT_EN
        s2_neg_d = s2_neg_q;
        uf_d     = uf_q || (s2_hs && s2_neg_q);
`endif

        if (in_good) begin
            s1_v_d   = 1'b1;
            s1_sum_d = AW'(e[DW-3]) + AW'(e[DW-4:0]);
            s1_sub_d = BW'(e[DW-3]) + BW'(c[DW-2:DW-3]);
            s1_ch_d  = in_ch;
        end

        if (s1_adv) begin
            s2_v_d   = 1'b1;
            s2_ch_d  = s1_ch_q;
            s2_seq_d = seq_sel;
`ifdef SEEK_F_SAT_EN
            s2_f_d   = wide[XW-1] ? '0 : wide[FW-1:0];
            s2_neg_d = wide[XW-1];
`else
            s2_f_d   = wide[FW-1:0];
`endif
        end

        for (int i = 0; i < NCH; i++) begin
            if (s2_hs && s2_ch_q == CW'(i)) cnt_d[i] = cnt_q[i] + SQW'(1);
        end

        if (clr) begin
            s1_v_d   = 1'b0;
            s2_v_d   = 1'b0;
            cnt_d    = '0;
            ch_err_d = 1'b0;
`ifdef SEEK_F_SAT_EN
            uf_d     = 1'b0;
`endif
        end

        // Output payload reads as zero whenever nothing is offered.
        if (!s2_v_d) begin
            s2_f_d   = '0;
            s2_ch_d  = '0;
            s2_seq_d = '0;
`ifdef SEEK_F_SAT_EN
            s2_neg_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q    <= 1'b0;
            s1_v_q   <= 1'b0;
            s1_sum_q <= '0;
            s1_sub_q <= '0;
            s1_ch_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_f_q   <= '0;
            s2_ch_q  <= '0;
            s2_seq_q <= '0;
            cnt_q    <= '0;
            ch_err_q <= 1'b0;
`ifdef SEEK_F_SAT_EN
            uf_q     <= 1'b0;
            s2_neg_q <= 1'b0;
`endif
        end else begin
            run_q    <= 1'b1;
            s1_v_q   <= s1_v_d;
            s1_sum_q <= s1_sum_d;
            s1_sub_q <= s1_sub_d;
            s1_ch_q  <= s1_ch_d;
            s2_v_q   <= s2_v_d;
            s2_f_q   <= s2_f_d;
            s2_ch_q  <= s2_ch_d;
            s2_seq_q <= s2_seq_d;
            cnt_q    <= cnt_d;
            ch_err_q <= ch_err_d;
`ifdef SEEK_F_SAT_EN
            uf_q     <= uf_d;
            s2_neg_q <= s2_neg_d;
`endif
        end
    end

    assign out_valid = s2_v_q;
    assign out_f     = s2_f_q;
    assign out_ch    = s2_ch_q;
    assign out_seq   = s2_seq_q;
    assign ch_err    = ch_err_q;
`ifdef SEEK_F_SAT_EN
    assign underflow = uf_q;
`endif

endmodule

// File: tb/tb_seek_f_pipe.sv
// Bench for seek_f_pipe: queue-based reference model of the pipeline plus directed cases,
// and a second NCH=5 instance for out-of-range channel handling.
module tb_seek_f_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clr, in_valid, out_ready;
    logic [1:0]  in_ch;
    logic [15:0] c, e;
    logic        in_ready, out_valid, ch_err;
    logic [35:0] out_f;
    logic [1:0]  out_ch;
    logic [7:0]  out_seq;

    logic        clr5, in_valid5, out_ready5;
    logic [2:0]  in_ch5;
    logic [15:0] c5, e5;
    logic        in_ready5, out_valid5, ch_err5;
    logic [35:0] out_f5;
    logic [2:0]  out_ch5;
    logic [7:0]  out_seq5;
`ifdef SEEK_F_SAT_EN
    logic        underflow, underflow5;
`endif

    seek_f_pipe dut (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .c(c), .e(e), .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_ch(out_ch), .out_seq(out_seq), .ch_err(ch_err)
`ifdef SEEK_F_SAT_EN
        , .underflow(underflow)
`endif
    );

    seek_f_pipe #(.NCH(5)) dut5 (
        .clk(clk), .reset(reset), .clr(clr5), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_ch(in_ch5), .c(c5), .e(e5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_f(out_f5), .out_ch(out_ch5), .out_seq(out_seq5), .ch_err(ch_err5)
`ifdef SEEK_F_SAT_EN
        , .underflow(underflow5)
`endif
    );

    typedef struct {
        logic [35:0] f;
        logic        neg;
        logic [1:0]  ch;
        int unsigned acc;
    } item_t;

    item_t       q[$];
    logic [7:0]  cnt_m [4];
    logic        run_m, uf_m;
    int unsigned edges;
    int          n_cmp, n_err;
    logic        last_acc, last_del;
    logic [7:0]  last_seq;

    function automatic item_t ref_beat(input logic [15:0] ee, input logic [15:0] cc, input logic [1:0] ch);
        longint v;
        item_t  it;
        v = ((longint'(ee[13]) + longint'(ee[12:0])) * (longint'(1) << 20))
            - longint'(ee[13]) - longint'(cc[14:13]);
        it.neg = (v < 0);
`ifdef SEEK_F_SAT_EN
        if (v < 0) v = 0;
`endif
        it.f   = 36'(v);
        it.ch  = ch;
        it.acc = 0;
        return it;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) cnt_m[i] = 8'd0;
        uf_m = 1'b0;
    endtask

    // Check outputs against the model, then advance the model across the coming edge.
    task automatic sample();
        logic  exp_rdy, fv;
        item_t it;
        exp_rdy = run_m && !clr && !(q.size() == 2 && !out_ready);
        chk("in_ready", in_ready, exp_rdy);
        fv = (q.size() > 0) && (edges - q[0].acc >= 2);
        chk("out_valid", out_valid, fv);
        if (fv) begin
            chk("out_f", out_f, q[0].f);
            chk("out_ch", out_ch, q[0].ch);
            chk("out_seq", out_seq, cnt_m[q[0].ch]);
        end else begin
            chk("out_f_idle", out_f, 0);
            chk("out_ch_idle", out_ch, 0);
            chk("out_seq_idle", out_seq, 0);
        end
        chk("ch_err", ch_err, 1'b0);
`ifdef SEEK_F_SAT_EN
        chk("underflow", underflow, uf_m);
`endif
        last_acc = 1'b0;
        last_del = 1'b0;
        last_seq = out_seq;
        if (clr) begin
            model_reset();
        end else begin
            if (fv && out_ready) begin
                last_del = 1'b1;
                if (q[0].neg) uf_m = 1'b1;
                cnt_m[q[0].ch] = cnt_m[q[0].ch] + 8'd1;
                void'(q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                last_acc = 1'b1;
                it = ref_beat(e, c, in_ch);
                it.acc = edges;
                q.push_back(it);
            end
        end
        run_m = reset;
        edges++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, got;
        n_cmp = 0; n_err = 0; edges = 0; run_m = 1'b0;
        model_reset();
        reset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ch = 2'd0; c = 16'd0; e = 16'd0;
        clr5 = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b1; in_ch5 = 3'd0; c5 = 16'd0; e5 = 16'd0;
        @(posedge clk); #1;

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_f", out_f, 0);
        chk("rst_out_seq", out_seq, 0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_ch_err", ch_err, 1'b0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Known vector: result two cycles after presentation.
        out_ready = 1'b1; in_valid = 1'b1; in_ch = 2'd1; e = 16'h2001; c = 16'h6000;
        tick(); in_valid = 1'b0; tick();
        chk("v1_valid", out_valid, 1'b1);
        chk("v1_f", out_f, 36'h0001FFFFC);
        chk("v1_ch", out_ch, 2'd1);
        chk("v1_seq", out_seq, 8'd0);
        tick();

        // Negative full-precision result.
        in_valid = 1'b1; in_ch = 2'd0; e = 16'h0000; c = 16'h2000;
        tick(); in_valid = 1'b0; tick();
`ifdef SEEK_F_SAT_EN
        chk("neg_f", out_f, 36'h0);
        tick();
        chk("neg_uf", underflow, 1'b1);
`else
        chk("neg_f", out_f, 36'hFFFFFFFFF);
        tick();
`endif

        // Back-to-back beats, no bubble.
        in_valid = 1'b1; in_ch = 2'd3; e = 16'h3FFF; c = 16'h0000;
        tick(); e = 16'h1FFF; tick(); in_valid = 1'b0;
        chk("b2b_v0", out_valid, 1'b1);
        chk("b2b_f0", out_f, 36'h1FFFFFFFF);
        tick();
        chk("b2b_v1", out_valid, 1'b1);
        chk("b2b_f1", out_f, 36'h1FFF00000);
        tick();
        chk("b2b_drain", out_valid, 1'b0);

        // Ten beats on channel 2 under alternating backpressure.
        clr = 1'b1; tick(); clr = 1'b0;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (sent < 10);
            in_ch     = 2'd2;
            e         = 16'($urandom);
            c         = 16'($urandom);
            tick();
            if (last_acc) sent++;
            if (last_del) begin
                chk("stall_seq", last_seq, 8'(got));
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stall_count", 64'(got), 64'd10);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0; in_valid = 1'b1; in_ch = 2'd1; e = 16'h2001; c = 16'h0000;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("full_valid", out_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        model_reset(); run_m = 1'b0;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_f", out_f, 0);
        chk("arst_ch", out_ch, 0);
        chk("arst_seq", out_seq, 0);
        chk("arst_in_ready", in_ready, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        out_ready = 1'b1; in_valid = 1'b1; in_ch = 2'd1;
        tick(); in_valid = 1'b0; tick();
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_seq", out_seq, 8'd0);
        tick();

        // Randomised traffic with occasional flushes and negative-result operands.
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_ch     = 2'($urandom);
            e         = (($urandom % 4) == 0) ? (16'($urandom) & 16'hC000) : 16'($urandom);
            c         = 16'($urandom);
            clr       = ($urandom % 50) == 0;
            tick();
        end
        in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();

        // Out-of-range channel on the NCH=5 instance.
        in_valid5 = 1'b1; in_ch5 = 3'd5; e5 = 16'h2001; c5 = 16'h6000;
        tick(); in_valid5 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bad_ch_valid", out_valid5, 1'b0);
        end
        chk("ch_err_set", ch_err5, 1'b1);
        in_valid5 = 1'b1; in_ch5 = 3'd2;
        tick(); in_valid5 = 1'b0; tick();
        chk("n5_valid", out_valid5, 1'b1);
        chk("n5_f", out_f5, 36'h0001FFFFC);
        chk("n5_ch", out_ch5, 3'd2);
        chk("n5_seq0", out_seq5, 8'd0);
        tick();
        in_valid5 = 1'b1;
        tick(); in_valid5 = 1'b0; tick();
        chk("n5_seq1", out_seq5, 8'd1);
        chk("ch_err_sticky", ch_err5, 1'b1);
        tick();
        clr5 = 1'b1; tick(); clr5 = 1'b0;
        chk("ch_err_clr", ch_err5, 1'b0);
        in_valid5 = 1'b1;
        tick(); in_valid5 = 1'b0; tick();
        chk("n5_clr_valid", out_valid5, 1'b1);
        chk("n5_clr_seq", out_seq5, 8'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
